// File: rtl/button_conditioner.sv
// button_conditioner: turns the two raw, bouncing push-buttons into clean
// one-cycle left/right request pulses for the tail-light sequencer.
// Each channel: 2-flop synchronizer -> debounce counter/stable value ->
// press-edge detect. A single arbiter gates requests against busy.
// Optional build macro BTN_HOLD_REQUEST_EN: a press arriving while busy is
// held in a one-entry pending register instead of being dropped.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic busy,
  output logic left,
  output logic right,
  output logic drop
);

  // Terminal debounce count; reaching it always flips the stable value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is left, 1 is right.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       stb;
  logic [1:0]       stb_d;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       ev;

  logic left_nxt;
  logic right_nxt;
  logic drop_nxt;

  assign raw = {btn_right_raw, btn_left_raw};

  // Two-flop synchronizer on both raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: stb follows s2 only after it has differed for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous stable value, used to see the 0->1 press edge for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_d <= '0;
    end else begin
      stb_d <= stb;
    end
  end

  // Press edge only; releases are debounced but produce no event.
  assign ev = stb & ~stb_d;

`ifdef BTN_HOLD_REQUEST_EN

  logic pend_vld;
  logic pend_dir;   // 0 = left, 1 = right
  logic busy_q;
  logic pend_vld_nxt;
  logic pend_dir_nxt;

  // Pending-request state and the busy value seen at the previous edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld <= 1'b0;
      pend_dir <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pend_vld <= pend_vld_nxt;
      pend_dir <= pend_dir_nxt;
      busy_q   <= busy;
    end
  end

  // Arbitration: a held request goes out on the edge after busy was sampled
  // low; while it is held, any further press is discarded (first one wins).
  always_comb begin
    left_nxt     = 1'b0;
    right_nxt    = 1'b0;
    drop_nxt     = 1'b0;
    pend_vld_nxt = pend_vld;
    pend_dir_nxt = pend_dir;
    if (pend_vld && !busy_q) begin
      left_nxt     = ~pend_dir;
      right_nxt    = pend_dir;
      pend_vld_nxt = 1'b0;
    end
    if (ev[0] && ev[1]) begin
      drop_nxt = 1'b1;
    end else if (ev[0] || ev[1]) begin
      if (pend_vld) begin
        drop_nxt = 1'b1;
      end else if (busy) begin
        pend_vld_nxt = 1'b1;
        pend_dir_nxt = ev[1];
      end else begin
        left_nxt  = ev[0];
        right_nxt = ev[1];
      end
    end
  end

`else

  // Arbitration: simultaneous presses or a press while busy are discarded.
  always_comb begin
    left_nxt  = ev[0] & ~ev[1] & ~busy;
    right_nxt = ev[1] & ~ev[0] & ~busy;
    drop_nxt  = (ev[0] & ev[1]) | ((ev[0] ^ ev[1]) & busy);
  end

`endif

  // Registered request and drop pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left  <= 1'b0;
      right <= 1'b0;
      drop  <= 1'b0;
    end else begin
      left  <= left_nxt;
      right <= right_nxt;
      drop  <= drop_nxt;
    end
  end

endmodule
